// File: rtl/vga_text_timing.sv
// Programmable VGA timing generator with character-cell coordinates and a text-entry cursor.
// Video outputs are registered from the raster counters, so they are mutually aligned.
module vga_text_timing #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter bit          SYNC_POL     = 1'b0,
    parameter int unsigned CELL_W       = 8,
    parameter int unsigned CELL_H       = 16,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned COLS    = H_ACTIVE / CELL_W,
    localparam int unsigned ROWS    = V_ACTIVE / CELL_H,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL),
    localparam int unsigned CW      = $clog2(COLS),
    localparam int unsigned RW      = $clog2(ROWS),
    localparam int unsigned AW      = $clog2(COLS * ROWS),
    localparam int unsigned GCW     = $clog2(CELL_W),
    localparam int unsigned GRW     = $clog2(CELL_H)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cur_adv,
    input  logic           cur_back,
    input  logic           cur_newline,
    input  logic           cur_home,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic [XW-1:0]  pix_x,
    output logic [YW-1:0]  pix_y,
    output logic [CW-1:0]  cell_col,
    output logic [RW-1:0]  cell_row,
    output logic [GCW-1:0] glyph_col,
    output logic [GRW-1:0] glyph_row,
    output logic           frame_start,
    output logic [CW-1:0]  cursor_col,
    output logic [RW-1:0]  cursor_row,
    output logic           cursor_hit,
    output logic           cur_wr,
    output logic [AW-1:0]  cur_wr_addr
);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [GRW-1:0] UL_ROW  = GRW'(CELL_H - 2);
    localparam int unsigned   FW       = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] BF_LAST  = FW'(BLINK_FRAMES - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          wr_d;
    logic [AW-1:0] cur_addr;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          blink_q, blink_d;

    // Raster counters
    always_comb begin
        x_d = x_q + XW'(1);
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_x       <= '0;
            pix_y       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_x       <= x_q;
            pix_y       <= y_q;
            hsync       <= (x_q >= HS_START && x_q <= HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (y_q >= VS_START && y_q <= VS_END) ? SYNC_POL : ~SYNC_POL;
            display_on  <= (x_q < X_ACT) && (y_q < Y_ACT);
            frame_start <= (x_q == '0) && (y_q == '0);
        end
    end

    assign cell_col  = pix_x[GCW +: CW];
    assign cell_row  = pix_y[GRW +: RW];
    assign glyph_col = pix_x[GCW-1:0];
    assign glyph_row = pix_y[GRW-1:0];

    // Cursor commands, highest priority first; only the winner acts
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        wr_d     = 1'b0;
        cur_addr = AW'(row_q) * AW'(COLS) + AW'(col_q);
        if (cur_home) begin
            col_d = '0;
            row_d = '0;
        end else if (cur_newline) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        end else if (cur_back) begin
            if (col_q != '0) begin
                col_d = col_q - CW'(1);
            end else if (row_q != '0) begin
                col_d = LAST_COL;
                row_d = row_q - RW'(1);
            end
        end else if (cur_adv) begin
            wr_d = 1'b1;
            if (col_q != LAST_COL) begin
                col_d = col_q + CW'(1);
            end else begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            cur_wr      <= 1'b0;
            cur_wr_addr <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            cur_wr      <= wr_d;
            cur_wr_addr <= cur_addr;
        end
    end

    assign cursor_col = col_q;
    assign cursor_row = row_q;

    // Blink phase flips after BLINK_FRAMES frame starts
    always_comb begin
        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        if (frame_start) begin
            if (fcnt_q == BF_LAST) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q  <= '0;
            blink_q <= 1'b1;
        end else begin
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        cursor_hit = display_on && blink_q && (cell_col == col_q) && (cell_row == row_q) &&
                     (glyph_row >= UL_ROW);
    end

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing: a default-geometry instance and a small fast-frame instance,
// both checked every cycle against an arithmetic raster/cursor model.
module tb_vga_text_timing;

    typedef struct {
        int unsigned x, y, cc, cr, gc, gr, ccol, crow, addr;
        bit hs, vs, de, fs, hit, wr;
    } obs_t;

    typedef struct {
        int unsigned ha, hf, hsw, hb, va, vf, vsw, vb, cw, ch, bf, cols, rows;
        bit pol;
    } geo_t;

    typedef struct {
        int h, nl, bk, ad, col, row, wr, addr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, cur_adv, cur_back, cur_newline, cur_home;

    logic d_hs, d_vs, d_de, d_fs, d_hit, d_wr;
    logic [9:0] d_px, d_py;
    logic [6:0] d_cc, d_ccol;
    logic [4:0] d_cr, d_crow;
    logic [2:0] d_gc;
    logic [3:0] d_gr;
    logic [11:0] d_addr;

    logic s_hs, s_vs, s_de, s_fs, s_hit, s_wr;
    logic [5:0] s_px, s_py;
    logic [1:0] s_cc, s_cr, s_ccol, s_crow;
    logic [2:0] s_gc, s_gr;
    logic [3:0] s_addr;

    vga_text_timing u_dut_def (
        .clk(clk), .reset(reset), .cur_adv(cur_adv), .cur_back(cur_back),
        .cur_newline(cur_newline), .cur_home(cur_home),
        .hsync(d_hs), .vsync(d_vs), .display_on(d_de), .pix_x(d_px), .pix_y(d_py),
        .cell_col(d_cc), .cell_row(d_cr), .glyph_col(d_gc), .glyph_row(d_gr),
        .frame_start(d_fs), .cursor_col(d_ccol), .cursor_row(d_crow), .cursor_hit(d_hit),
        .cur_wr(d_wr), .cur_wr_addr(d_addr)
    );

    vga_text_timing #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(1'b1), .CELL_W(8), .CELL_H(8), .BLINK_FRAMES(3)
    ) u_dut_small (
        .clk(clk), .reset(reset), .cur_adv(cur_adv), .cur_back(cur_back),
        .cur_newline(cur_newline), .cur_home(cur_home),
        .hsync(s_hs), .vsync(s_vs), .display_on(s_de), .pix_x(s_px), .pix_y(s_py),
        .cell_col(s_cc), .cell_row(s_cr), .glyph_col(s_gc), .glyph_row(s_gr),
        .frame_start(s_fs), .cursor_col(s_ccol), .cursor_row(s_crow), .cursor_hit(s_hit),
        .cur_wr(s_wr), .cur_wr_addr(s_addr)
    );

    obs_t od, os;
    always_comb begin
        od.x = 32'(d_px);  od.y = 32'(d_py);  od.cc = 32'(d_cc);  od.cr = 32'(d_cr);
        od.gc = 32'(d_gc); od.gr = 32'(d_gr); od.ccol = 32'(d_ccol); od.crow = 32'(d_crow);
        od.addr = 32'(d_addr); od.hs = d_hs; od.vs = d_vs; od.de = d_de; od.fs = d_fs;
        od.hit = d_hit; od.wr = d_wr;
        os.x = 32'(s_px);  os.y = 32'(s_py);  os.cc = 32'(s_cc);  os.cr = 32'(s_cr);
        os.gc = 32'(s_gc); os.gr = 32'(s_gr); os.ccol = 32'(s_ccol); os.crow = 32'(s_crow);
        os.addr = 32'(s_addr); os.hs = s_hs; os.vs = s_vs; os.de = s_de; os.fs = s_fs;
        os.hit = s_hit; os.wr = s_wr;
    end

    geo_t gd, gs;
    int unsigned total = 0, bad = 0;
    int unsigned n = 0;              // edges since reset released; 0 = reset state
    bit chk = 1'b0;
    int unsigned pd = 0, ps = 0;     // model cursor as linear cell index
    bit wd = 1'b0, ws = 1'b0;
    int unsigned ad_d = 0, ad_s = 0;

    task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic void step(inout int unsigned pos, input int unsigned cols,
                                 input int unsigned rows, input bit h, input bit nl,
                                 input bit bk, input bit ad, output bit wr,
                                 output int unsigned addr);
        wr = 1'b0;
        addr = pos;
        if (h) pos = 0;
        else if (nl) pos = ((pos / cols + 1) % rows) * cols;
        else if (bk) begin
            if (pos > 0) pos = pos - 1;
        end else if (ad) begin
            wr = 1'b1;
            pos = (pos + 1) % (cols * rows);
        end
    endfunction

    task automatic check_inst(input string t, input geo_t g, input obs_t o, input int unsigned pos,
                              input bit wr, input int unsigned addr);
        int unsigned ht, vt, ft, p, x, y, fc;
        bit bl, de, hs, vs, fs, hit;
        ht = g.ha + g.hf + g.hsw + g.hb;
        vt = g.va + g.vf + g.vsw + g.vb;
        ft = ht * vt;
        if (n == 0) begin
            x = 0; y = 0; hs = ~g.pol; vs = ~g.pol; de = 0; fs = 0; bl = 1;
        end else begin
            p = n - 1;
            x = p % ht;
            y = (p / ht) % vt;
            hs = (x >= g.ha + g.hf && x < g.ha + g.hf + g.hsw) ? g.pol : ~g.pol;
            vs = (y >= g.va + g.vf && y < g.va + g.vf + g.vsw) ? g.pol : ~g.pol;
            de = (x < g.ha) && (y < g.va);
            fs = (p % ft) == 0;
            fc = (p == 0) ? 0 : (p - 1) / ft + 1;
            bl = ((fc / g.bf) % 2) == 0;
        end
        hit = de && bl && (x / g.cw == pos % g.cols) && (y / g.ch == pos / g.cols) &&
              (y % g.ch >= g.ch - 2);
        cmp({t, ".pix_x"}, o.x, x);
        cmp({t, ".pix_y"}, o.y, y);
        cmp({t, ".hsync"}, o.hs, hs);
        cmp({t, ".vsync"}, o.vs, vs);
        cmp({t, ".display_on"}, o.de, de);
        cmp({t, ".frame_start"}, o.fs, fs);
        cmp({t, ".cursor_col"}, o.ccol, pos % g.cols);
        cmp({t, ".cursor_row"}, o.crow, pos / g.cols);
        cmp({t, ".cursor_hit"}, o.hit, hit);
        cmp({t, ".cur_wr"}, o.wr, wr);
        if (wr) cmp({t, ".cur_wr_addr"}, o.addr, addr);
        if (de) begin
            cmp({t, ".cell_col"}, o.cc, x / g.cw);
            cmp({t, ".cell_row"}, o.cr, y / g.ch);
            cmp({t, ".glyph_col"}, o.gc, x % g.cw);
            cmp({t, ".glyph_row"}, o.gr, y % g.ch);
        end
    endtask

    task automatic tick(input bit rs, input bit h, input bit nl, input bit bk, input bit ad);
        reset = rs; cur_home = h; cur_newline = nl; cur_back = bk; cur_adv = ad;
        @(posedge clk);
        if (rs) begin
            n = 0; pd = 0; ps = 0; wd = 0; ws = 0; chk = 1'b1;
        end else begin
            n++;
            step(pd, gd.cols, gd.rows, h, nl, bk, ad, wd, ad_d);
            step(ps, gs.cols, gs.rows, h, nl, bk, ad, ws, ad_s);
        end
        #1;
        if (chk) begin
            check_inst("def", gd, od, pd, wd, ad_d);
            check_inst("small", gs, os, ps, ws, ad_s);
        end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl[13];
    int unsigned hcnt, hit_cnt, de_cnt, last_fs;
    bit line_ok, have_fs;

    initial begin
        gd = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33,
               cw: 8, ch: 16, bf: 30, cols: 80, rows: 30, pol: 1'b0};
        gs = '{ha: 32, hf: 4, hsw: 6, hb: 6, va: 32, vf: 2, vsw: 2, vb: 4,
               cw: 8, ch: 8, bf: 3, cols: 4, rows: 4, pol: 1'b1};
        //           h  nl bk ad col row wr addr   (default 80x30 geometry)
        tbl[0]  = '{0, 0, 1, 0, 0,  0,  0, 0};
        tbl[1]  = '{0, 0, 0, 1, 1,  0,  1, 0};
        tbl[2]  = '{0, 0, 1, 0, 0,  0,  0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0,  1,  0, 0};
        tbl[4]  = '{0, 0, 1, 0, 79, 0,  0, 0};
        tbl[5]  = '{0, 0, 0, 1, 0,  1,  1, 79};
        tbl[6]  = '{0, 1, 0, 0, 0,  2,  0, 0};
        tbl[7]  = '{0, 1, 1, 1, 0,  3,  0, 0};
        tbl[8]  = '{0, 0, 1, 1, 79, 2,  0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0,  3,  1, 239};
        tbl[10] = '{1, 0, 0, 1, 0,  0,  0, 0};
        tbl[11] = '{0, 0, 0, 1, 1,  0,  1, 0};
        tbl[12] = '{1, 1, 1, 1, 0,  0,  0, 0};

        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 13; i++) begin
            tick(1'b0, tbl[i].h != 0, tbl[i].nl != 0, tbl[i].bk != 0, tbl[i].ad != 0);
            cmp($sformatf("tbl%0d.col", i), od.ccol, tbl[i].col);
            cmp($sformatf("tbl%0d.row", i), od.crow, tbl[i].row);
            cmp($sformatf("tbl%0d.wr", i), od.wr, tbl[i].wr);
            if (tbl[i].wr != 0) cmp($sformatf("tbl%0d.addr", i), od.addr, tbl[i].addr);
        end

        // 80 writes walk the first row, addresses 0..79
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cmp("adv80.wr", od.wr, 1);
            cmp("adv80.addr", od.addr, i);
        end
        cmp("adv80.end_col", od.ccol, 0);
        cmp("adv80.end_row", od.crow, 1);

        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2400; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("adv2400.col", od.ccol, 0);
        cmp("adv2400.row", od.crow, 0);

        // Home beats adv at (5,3)
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("pre_home.col", od.ccol, 5);
        cmp("pre_home.row", od.crow, 3);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cmp("home_adv.col", od.ccol, 0);
        cmp("home_adv.row", od.crow, 0);
        cmp("home_adv.wr", od.wr, 0);

        // Park cursor at (2,2) on both instances and let the raster run
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("park.col", od.ccol, 2);
        cmp("park.row", od.crow, 2);

        hcnt = 0; hit_cnt = 0; de_cnt = 0; last_fs = 0; line_ok = 0; have_fs = 0;
        while (n < 40010) begin
            idle();
            if ((n - 1) % 800 == 0) begin
                hcnt = 0;
                line_ok = 1;
            end
            if (!od.hs) hcnt++;
            if ((n - 1) % 800 == 799 && line_ok) cmp("def.hsync_width", hcnt, 96);
            if (od.hit) hit_cnt++;
            if (n - 1 == 35 * 800 + 17) begin
                cmp("pt.cell_col", od.cc, 2);
                cmp("pt.glyph_col", od.gc, 1);
                cmp("pt.cell_row", od.cr, 2);
                cmp("pt.glyph_row", od.gr, 3);
            end
            if (os.fs) begin
                if (have_fs) begin
                    cmp("small.frame_period", n - last_fs, 1920);
                    cmp("small.de_per_frame", de_cnt, 1024);
                end
                have_fs = 1;
                last_fs = n;
                de_cnt = 0;
            end
            if (os.de) de_cnt++;
        end
        cmp("def.hit_pixels", hit_cnt, 16);

        for (int i = 0; i < 3000; i++) begin
            tick(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0);
        end

        // Mid-frame reset on the small instance's raster
        for (int k = 0; k < 2000 && ((n - 1) % 1920) != 300; k++) idle();
        cmp("pre_rst.small_pix_x", os.x, 12);
        cmp("pre_rst.small_pix_y", os.y, 6);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("rst.pix_x", os.x, 0);
        cmp("rst.hsync_small", os.hs, 0);
        cmp("rst.hsync_def", od.hs, 1);
        cmp("rst.cur_wr", od.wr, 0);
        idle();
        cmp("rst.first_frame_start", os.fs, 1);
        for (int i = 0; i < 4000; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_text_timing.md
Name: vga_text_timing

Overview:
- Parametrised successor to the fixed 640x480 sync generator: programmable H/V timing, sync polarity and character-cell geometry.
- Produces aligned sync, active-video, pixel and cell/glyph coordinates, plus a text-entry cursor with wrap, backspace, newline and blink.
- Emits a write strobe and linear cell address for the character-buffer write port.
- Sits between the debounced keypad/switch logic and the glyph ROM / character buffer / RGB output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync
- CELL_W, 8, glyph width in pixels (power of 2)
- CELL_H, 16, glyph height in pixels (power of 2)
- BLINK_FRAMES, 30, frames per blink phase (>=1)
- Derived: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise, COLS=H_ACTIVE/CELL_W, ROWS=V_ACTIVE/CELL_H.
- Derived widths: XW=clog2(H_TOTAL), YW=clog2(V_TOTAL), CW=clog2(COLS), RW=clog2(ROWS), AW=clog2(COLS*ROWS).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- cur_adv  in  1  one-cycle pulse: write cell at cursor, then advance
- cur_back  in  1  one-cycle pulse: backspace
- cur_newline  in  1  one-cycle pulse: column 0, next row
- cur_home  in  1  one-cycle pulse: cursor to (0,0)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_on  out  1  pixel is in the active area
- pix_x  out  XW  pixel column
- pix_y  out  YW  line number
- cell_col  out  CW  pix_x/CELL_W
- cell_row  out  RW  pix_y/CELL_H
- glyph_col  out  clog2(CELL_W)  pix_x%CELL_W
- glyph_row  out  clog2(CELL_H)  pix_y%CELL_H
- frame_start  out  1  pulse with pix_x==0 and pix_y==0
- cursor_col  out  CW  cursor column
- cursor_row  out  RW  cursor row
- cursor_hit  out  1  draw cursor underline at this pixel
- cur_wr  out  1  character-buffer write strobe
- cur_wr_addr  out  AW  cursor_row*COLS+cursor_col, sampled before the move

Behaviour:
- Internal x counter runs 0..H_TOTAL-1 and wraps to 0. The y counter increments when x wraps and itself wraps at V_TOTAL-1. There is no off-by-one: the line period is exactly H_TOTAL clocks.
- All video outputs are registered from the counters and are therefore mutually aligned, one clock after the counters.
- hsync = SYNC_POL when pix_x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise ~SYNC_POL.
- vsync = SYNC_POL when pix_y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise ~SYNC_POL.
- display_on = (pix_x<H_ACTIVE) && (pix_y<V_ACTIVE).
- Cell and glyph fields are bit slices of pix_x/pix_y. They are don't-care while display_on=0.
- Cursor command priority: home > newline > back > adv. Only the winning command acts; the others are dropped. Any change is visible on cursor_col/row the next cycle.
- adv: cur_wr=1 for one cycle with cur_wr_addr = the pre-move address. Then:
  - col<COLS-1: col+1.
  - Otherwise col=0 and row+1.
  - At (COLS-1, ROWS-1) the cursor wraps to (0,0).
- back:
  - col>0: col-1.
  - col==0 and row>0: (COLS-1, row-1).
  - At (0,0): no change. No write.
- newline: col=0 and row+1, wrapping to row 0 after ROWS-1. No write.
- home: (0,0). No write.
- cur_wr is asserted only when adv is the winning command.
- Blink:
  - Frame counter increments on each frame_start.
  - On reaching BLINK_FRAMES it clears and blink toggles.
- cursor_hit = display_on & blink & (cell_col==cursor_col) & (cell_row==cursor_row) & (glyph_row>=CELL_H-2).
- Reset values (next edge, also when reset is asserted mid-frame): counters 0, pix_x=0, pix_y=0, hsync=vsync=~SYNC_POL, display_on=0, frame_start=0, cursor (0,0), cur_wr=0, blink=1, frame counter 0.
- Cursor inputs are ignored while reset is high.

Test Plan:
- Defaults, free run after reset: hsync low for exactly 96 clocks starting at pix_x=656; line period 800; vsync low during lines 490-491 only; frame_start every 420000 clocks.
- Count display_on per frame -> 307200. It is never high at pix_x>=640 or pix_y>=480.
- At pix_x=17, pix_y=35 -> cell_col=2, glyph_col=1, cell_row=2, glyph_row=3.
- 80 cur_adv pulses from (0,0):
  - cur_wr_addr sequence 0..79, cursor ends at (0,1).
  - Home, then 2400 pulses -> cursor back at (0,0).
- cur_back at (0,0) -> stays, no cur_wr. At (0,1) -> (79,0). cur_home+cur_adv in the same cycle at (5,3) -> (0,0), no cur_wr.
- Cursor at (2,2):
  - cursor_hit asserts only for pix_x 16-23 and pix_y 46-47.
  - It is absent during frames 30-59 after reset and returns at frame 60.
  - Reset pulse at pix_x=300, pix_y=200 -> all outputs at reset values, and the count restarts from 0.
